fizzbuzz_ascii_tx: RTL and testbench

Downstream consumer of the fizzbuzz flag generator. Accepts one token per handshake: a counter value plus its fizz/buzz/fizzbuzz flags. Emits the matching ASCII text ("Fizz", "Buzz", "FizzBuzz", or the value in unsigned decimal) as a valid/ready byte stream, optionally followed by a newline, for a UART or log sink.

---
 rtl/fizzbuzz_pkg.sv | 49 ++++
 rtl/fizzbuzz_bin2bcd.sv | 64 ++++++
 rtl/fizzbuzz_ascii_tx.sv | 222 ++++++++++++++++++++++
 tb/tb_fizzbuzz_ascii_tx.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fizzbuzz_pkg.sv
// Shared definitions for the fizzbuzz ASCII transmitter.
// Holds the ASCII byte constants, the transmitter state encoding, the
// "FizzBuzz" text table ("Fizz" and "Buzz" are slices of it) and a helper
// that derives the decimal digit count of the largest accepted value.
package fizzbuzz_pkg;

    localparam logic [7:0] CH_F  = 8'h46;
    localparam logic [7:0] CH_I  = 8'h69;
    localparam logic [7:0] CH_Z  = 8'h7A;
    localparam logic [7:0] CH_B  = 8'h42;
    localparam logic [7:0] CH_U  = 8'h75;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_LF = 8'h0A;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TEXT,
        ST_CONV,
        ST_SKIP,
        ST_DIGITS,
        ST_NL
    } tx_state_t;

    localparam logic [7:0] FIZZBUZZ_STR [8] = '{CH_F, CH_I, CH_Z, CH_Z,
                                                CH_B, CH_U, CH_Z, CH_Z};

    // Index ranges of the two words inside FIZZBUZZ_STR.
    localparam logic [2:0] FIZZ_FIRST = 3'd0;
    localparam logic [2:0] FIZZ_END   = 3'd3;
    localparam logic [2:0] BUZZ_FIRST = 3'd4;
    localparam logic [2:0] BUZZ_END   = 3'd7;

    function automatic int unsigned calc_nd(input int unsigned max_value);
        int unsigned v;
        int unsigned n;
        v = max_value;
        n = 1;
        for (int unsigned i = 0; i < 10; i++) begin
            if (v >= 10) begin
                v = v / 10;
                n = n + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fizzbuzz_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   start       : load bin and perform the first shift on this edge
//   bin         : VW-bit binary value
//   done        : high in the cycle whose closing edge performs the final shift
//   bcd         : ND packed BCD digits, digit 0 in the low nibble
module fizzbuzz_bin2bcd
    import fizzbuzz_pkg::*;
#(
    parameter int unsigned VW = 8,
    parameter int unsigned ND = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [VW-1:0]         bin,
    output logic                  done,
    output logic [ND*DIGIT_W-1:0] bcd
);

    localparam int unsigned CW = $clog2(VW + 1);
    localparam int unsigned BW = ND * DIGIT_W;

    logic [VW-1:0] sr_q, sr_d, sr_src;
    logic [BW-1:0] bcd_q, bcd_d, bcd_adj;
    logic [CW-1:0] cnt_q, cnt_d;

    // The load edge already performs the first shift, so only VW-1 further
    // shifts remain after start.
    always_comb begin
        sr_d    = sr_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        sr_src  = start ? bin : sr_q;
        bcd_adj = start ? '0 : bcd_q;
        if (start || (cnt_q != '0)) begin
            for (int unsigned i = 0; i < ND; i++) begin
                if (bcd_adj[i*DIGIT_W +: DIGIT_W] >= 4'd5) begin
                    bcd_adj[i*DIGIT_W +: DIGIT_W] = bcd_adj[i*DIGIT_W +: DIGIT_W] + 4'd3;
                end
            end
            bcd_d = {bcd_adj[BW-2:0], sr_src[VW-1]};
            sr_d  = sr_src << 1;
            cnt_d = start ? CW'(VW - 1) : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sr_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == CW'(1));
    assign bcd  = bcd_q;

endmodule

// File: rtl/fizzbuzz_ascii_tx.sv
// Converts one fizzbuzz token (value + flags) into an ASCII byte stream:
// "FizzBuzz", "Fizz", "Buzz" or the unsigned decimal value, optionally
// terminated by a line feed.
// Ports:
//   clk, resetn                         : clock, asynchronous active-low reset
//   in_valid/in_ready                   : token handshake (ready only when idle)
//   in_value, in_fizz, in_buzz, in_fizzbuzz : token payload
//   out_valid/out_ready                 : byte handshake
//   out_data                            : ASCII byte (registered)
//   out_last                            : final byte of the message
module fizzbuzz_ascii_tx
    import fizzbuzz_pkg::*;
#(
    parameter  int unsigned MAX_VALUE = 255,
    parameter  bit          NEWLINE   = 1'b1,
    localparam int unsigned VW        = $clog2(MAX_VALUE + 1),
    localparam int unsigned ND        = calc_nd(MAX_VALUE)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [VW-1:0] in_value,
    input  logic          in_fizz,
    input  logic          in_buzz,
    input  logic          in_fizzbuzz,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          out_last
);

    localparam int unsigned IW = $clog2(ND + 1);

    tx_state_t state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic [2:0]    txt_idx_q, txt_idx_d;
    logic [2:0]    txt_end_q, txt_end_d;
    logic [2:0]    txt_next;
    logic [IW-1:0] dig_q, dig_d;

    logic                  accept;
    logic                  out_fire;
    logic                  text_msg;
    logic                  msg_done;
    logic                  conv_start;
    logic                  conv_done;
    logic [ND*DIGIT_W-1:0] bcd;
    logic [DIGIT_W-1:0]    cur_digit;
    logic [DIGIT_W-1:0]    nxt_digit;

    fizzbuzz_bin2bcd #(
        .VW (VW),
        .ND (ND)
    ) u_bin2bcd (
        .clk    (clk),
        .resetn (resetn),
        .start  (conv_start),
        .bin    (in_value),
        .done   (conv_done),
        .bcd    (bcd)
    );

    assign accept   = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;
    assign txt_next = txt_idx_q + 3'd1;

    // dig_q counts digits still to emit; the current digit is dig_q-1.
    always_comb begin
        cur_digit = '0;
        nxt_digit = '0;
        for (int unsigned i = 0; i < ND; i++) begin
            if (32'(dig_q) == i + 1) cur_digit = bcd[i*DIGIT_W +: DIGIT_W];
            if (32'(dig_q) == i + 2) nxt_digit = bcd[i*DIGIT_W +: DIGIT_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        txt_idx_d   = txt_idx_q;
        txt_end_d   = txt_end_q;
        dig_d       = dig_q;
        text_msg    = 1'b0;
        msg_done    = 1'b0;
        conv_start  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_fizzbuzz || (in_fizz && in_buzz)) begin
                        text_msg  = 1'b1;
                        txt_idx_d = FIZZ_FIRST;
                        txt_end_d = BUZZ_END;
                    end else if (in_fizz) begin
                        text_msg  = 1'b1;
                        txt_idx_d = FIZZ_FIRST;
                        txt_end_d = FIZZ_END;
                    end else if (in_buzz) begin
                        text_msg  = 1'b1;
                        txt_idx_d = BUZZ_FIRST;
                        txt_end_d = BUZZ_END;
                    end
                    if (text_msg) begin
                        state_d     = ST_TEXT;
                        out_valid_d = 1'b1;
                        out_data_d  = FIZZBUZZ_STR[txt_idx_d];
                        out_last_d  = 1'b0;
                    end else begin
                        conv_start = 1'b1;
                        dig_d      = IW'(ND);
                        state_d    = (VW > 1) ? ST_CONV : ST_SKIP;
                    end
                end
            end

            ST_TEXT: begin
                if (out_fire) begin
                    if (txt_idx_q == txt_end_q) begin
                        msg_done = 1'b1;
                    end else begin
                        txt_idx_d  = txt_next;
                        out_data_d = FIZZBUZZ_STR[txt_next];
                        out_last_d = !NEWLINE && (txt_next == txt_end_q);
                    end
                end
            end

            ST_CONV: begin
                if (conv_done) state_d = ST_SKIP;
            end

            ST_SKIP: begin
                // Leading zeros are dropped one per cycle; the units digit stays.
                if ((dig_q > IW'(1)) && (cur_digit == '0)) begin
                    dig_d = dig_q - 1'b1;
                end else begin
                    state_d     = ST_DIGITS;
                    out_valid_d = 1'b1;
                    out_data_d  = CH_0 + {4'h0, cur_digit};
                    out_last_d  = !NEWLINE && (dig_q == IW'(1));
                end
            end

            ST_DIGITS: begin
                if (out_fire) begin
                    if (dig_q == IW'(1)) begin
                        msg_done = 1'b1;
                    end else begin
                        dig_d      = dig_q - 1'b1;
                        out_data_d = CH_0 + {4'h0, nxt_digit};
                        out_last_d = !NEWLINE && (dig_q == IW'(2));
                    end
                end
            end

            ST_NL: begin
                if (out_fire) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase

        if (msg_done) begin
            if (NEWLINE) begin
                state_d     = ST_NL;
                out_valid_d = 1'b1;
                out_data_d  = CH_LF;
                out_last_d  = 1'b1;
            end else begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end

        // Registered so that in_ready stays low during reset and rises on the
        // first edge after release.
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            txt_idx_q   <= '0;
            txt_end_q   <= '0;
            dig_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            txt_idx_q   <= txt_idx_d;
            txt_end_q   <= txt_end_d;
            dig_q       <= dig_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_fizzbuzz_ascii_tx.sv
// Self-checking bench for fizzbuzz_ascii_tx: expected bytes are pushed to a
// scoreboard queue when a token is driven and compared as bytes leave the DUT.
module tb_fizzbuzz_ascii_tx;

    localparam int unsigned VW = 8;
    localparam int unsigned ND = 3;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn      = 1'b1;
    logic          in_valid    = 1'b0;
    logic [VW-1:0] in_value    = '0;
    logic          in_fizz     = 1'b0;
    logic          in_buzz     = 1'b0;
    logic          in_fizzbuzz = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready   = 1'b1;
    logic [7:0]    out_data;
    logic          out_last;

    logic          in_valid0   = 1'b0;
    logic [VW-1:0] in_value0   = '0;
    logic          in_ready0;
    logic          out_valid0;
    logic          out_ready0  = 1'b1;
    logic [7:0]    out_data0;
    logic          out_last0;

    logic rand_ready = 1'b0;

    fizzbuzz_ascii_tx #(.MAX_VALUE(255), .NEWLINE(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
        .in_fizz(in_fizz), .in_buzz(in_buzz), .in_fizzbuzz(in_fizzbuzz),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    fizzbuzz_ascii_tx #(.MAX_VALUE(255), .NEWLINE(1'b0)) dut_nonl (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_value(in_value0),
        .in_fizz(1'b0), .in_buzz(1'b0), .in_fizzbuzz(1'b0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_data(out_data0), .out_last(out_last0)
    );

    int unsigned n_checks    = 0;
    int unsigned n_pass      = 0;
    int unsigned cyc         = 0;
    int unsigned rx_count    = 0;
    int unsigned rx_expected = 0;

    exp_t        exp_q[$];
    exp_t        exp0_q[$];
    int unsigned lat_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
    end

    // Scoreboard model: text from the flags or the decimal string of the value.
    task automatic expect_msg(input int unsigned v, input logic f, input logic b,
                              input logic fb, input bit to_nonl);
        string s;
        exp_t  e;
        int    n;
        bit    is_text;
        is_text = fb || f || b;
        if (fb || (f && b)) s = "FizzBuzz";
        else if (f)         s = "Fizz";
        else if (b)         s = "Buzz";
        else                s = $sformatf("%0d", v);
        n = s.len();
        for (int i = 0; i < n; i++) begin
            e.data = s[i];
            e.last = to_nonl && (i == n - 1);
            if (to_nonl) exp0_q.push_back(e);
            else begin
                exp_q.push_back(e);
                rx_expected++;
            end
        end
        if (!to_nonl) begin
            e.data = 8'h0A;
            e.last = 1'b1;
            exp_q.push_back(e);
            rx_expected++;
            lat_q.push_back(is_text ? 1 : VW + 1 + (ND - n));
        end
    endtask

    // Monitor for the NEWLINE=1 instance.
    logic        tb_busy = 1'b0, want_ready = 1'b0, first_pend = 1'b0, stall_prev = 1'b0;
    logic        b2b_check = 1'b0;
    logic [7:0]  prev_data;
    logic        prev_last;
    int unsigned acc_edge, lat_exp, last_hs_edge;
    exp_t        e_mon;

    always @(negedge clk) begin
        if (!resetn) begin
            tb_busy    = 1'b0;
            want_ready = 1'b0;
            first_pend = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_last", out_last, prev_last);
            end
            if (want_ready) begin
                check("ready_after_last", in_ready, 1);
                want_ready = 1'b0;
            end
            if (tb_busy) check("ready_busy", in_ready, 0);
            if (first_pend && out_valid) begin
                check("first_latency", cyc - acc_edge + 1, lat_exp);
                first_pend = 1'b0;
            end
            if (out_valid && out_ready) begin
                rx_count++;
                if (exp_q.size() == 0) begin
                    check("extra_byte", rx_count, rx_expected);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("data", out_data, e_mon.data);
                    check("last", out_last, e_mon.last);
                end
                if (out_last) begin
                    tb_busy      = 1'b0;
                    want_ready   = 1'b1;
                    last_hs_edge = cyc + 1;
                end
            end
            if (in_valid && in_ready) begin
                acc_edge   = cyc + 1;
                tb_busy    = 1'b1;
                first_pend = 1'b1;
                if (lat_q.size() > 0) lat_exp = lat_q.pop_front();
                if (b2b_check) begin
                    check("b2b_accept_edge", acc_edge, last_hs_edge + 1);
                    b2b_check = 1'b0;
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // Monitor for the NEWLINE=0 instance.
    exp_t e_mon0;
    always @(negedge clk) begin
        if (resetn && out_valid0 && out_ready0) begin
            if (exp0_q.size() == 0) begin
                check("nonl_extra_byte", exp0_q.size(), 1);
            end else begin
                e_mon0 = exp0_q.pop_front();
                check("nonl_data", out_data0, e_mon0.data);
                check("nonl_last", out_last0, e_mon0.last);
            end
        end
    end

    task automatic wait_accept();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) check("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int unsigned v, input logic f, input logic b, input logic fb);
        expect_msg(v, f, b, fb, 1'b0);
        in_value    = VW'(v);
        in_fizz     = f;
        in_buzz     = b;
        in_fizzbuzz = fb;
        in_valid    = 1'b1;
        wait_accept();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && in_ready;
        end
        if (!done) check("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 resetn = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        check("rdy_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        check("rdy_after_edge", in_ready, 1);

        send(3, 1'b1, 1'b0, 1'b0);   wait_done();
        send(6, 1'b0, 1'b0, 1'b1);   wait_done();
        send(6, 1'b1, 1'b1, 1'b0);   wait_done();
        send(10, 1'b0, 1'b1, 1'b0);  wait_done();
        send(0, 1'b0, 1'b0, 1'b0);   wait_done();
        send(7, 1'b0, 1'b0, 1'b0);   wait_done();
        send(255, 1'b0, 1'b0, 1'b0); wait_done();
        send(42, 1'b0, 1'b0, 1'b0);  wait_done();

        // NEWLINE=0 instance: 105 -> "105", out_last on '5'.
        begin
            bit ok;
            expect_msg(105, 1'b0, 1'b0, 1'b0, 1'b1);
            in_value0 = VW'(105);
            in_valid0 = 1'b1;
            ok = 1'b0;
            for (int k = 0; k < 50 && !ok; k++) begin
                @(negedge clk);
                ok = in_ready0;
            end
            check("nonl_accept", in_ready0, 1);
            @(posedge clk);
            #1 in_valid0 = 1'b0;
            for (int k = 0; k < 100 && exp0_q.size() > 0; k++) @(negedge clk);
            check("nonl_drained", exp0_q.size(), 0);
            @(posedge clk);
            #1;
        end

        // Random out_ready stalls.
        rand_ready = 1'b1;
        send(200, 1'b0, 1'b0, 1'b0);
        wait_done();
        rand_ready = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back tokens with in_valid held high.
        expect_msg(9, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_msg(10, 1'b0, 1'b1, 1'b0, 1'b0);
        in_value = VW'(9); in_fizz = 1'b1; in_buzz = 1'b0; in_fizzbuzz = 1'b0;
        in_valid = 1'b1;
        wait_accept();
        in_value = VW'(10); in_fizz = 1'b0; in_buzz = 1'b1;
        b2b_check = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        wait_done();
        check("b2b_flag_consumed", b2b_check, 0);

        // Reset during the third byte of "FizzBuzz".
        send(30, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("third_byte", out_data, 8'h7A);
        resetn = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_last", out_last, 0);
        exp_q.delete();
        lat_q.delete();
        rx_expected = rx_count;
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        check("rel_ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        check("rel_ready_after_edge", in_ready, 1);
        repeat (20) @(posedge clk);
        #1;
        check("no_stale_bytes", rx_count, rx_expected);
        check("no_stale_valid", out_valid, 0);

        send(128, 1'b0, 1'b0, 1'b0); wait_done();

        check("all_consumed", exp_q.size(), 0);
        check("rx_total", rx_count, rx_expected);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
